// File: rtl/indirect_normal_acc_pkg.sv
// Shared configuration for the indirect-Jacobian normal-equation accumulator:
// fixed-point widths, packed upper-triangle index map and the frame FSM states.
package indirect_normal_acc_pkg;
    localparam int ID_COE_BW = 32;
    localparam int MUL       = 16;
    localparam int MATRIX_BW = 48;

    localparam int N_H    = 21;
    localparam int N_B    = 6;
    localparam int N_CELL = N_H + N_B;

    // (row, col) of packed H slot n, row-major over the upper triangle
    localparam int H_ROW [N_H] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 4, 4, 5};
    localparam int H_COL [N_H] = '{0, 1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 2, 3, 4, 5, 3, 4, 5, 4, 5, 5};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_DONE
    } acc_state_e;
endpackage

// File: rtl/indirect_normal_acc_mac_cell.sv
// One saturating signed accumulator; term is one bit wider so x+y sums never wrap
// before the saturation check.
module indirect_normal_acc_mac_cell #(
    parameter int ACC_BW = 48
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [ACC_BW:0]   term,
    output logic signed [ACC_BW-1:0] acc,
    output logic                     ovf
);
    localparam logic signed [ACC_BW+1:0] ACC_MAX = {3'b000, {(ACC_BW-1){1'b1}}};
    localparam logic signed [ACC_BW+1:0] ACC_MIN = {3'b111, {(ACC_BW-1){1'b0}}};

    logic signed [ACC_BW+1:0] sum;
    logic signed [ACC_BW-1:0] acc_d;

    always_comb begin
        sum   = {{2{acc[ACC_BW-1]}}, acc} + {term[ACC_BW], term};
        acc_d = sum[ACC_BW-1:0];
        ovf   = 1'b0;
        if (sum > ACC_MAX) begin
            acc_d = ACC_MAX[ACC_BW-1:0];
            ovf   = en;
        end else if (sum < ACC_MIN) begin
            acc_d = ACC_MIN[ACC_BW-1:0];
            ovf   = en;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc_d;
    end
endmodule

// File: rtl/indirect_normal_acc.sv
// Accumulates H = sum(A^T A) (upper triangle) and b = sum(A^T d) over a frame of
// indirect Jacobian samples through a 3-stage register/multiply/accumulate pipe.
module indirect_normal_acc
    import indirect_normal_acc_pkg::*;
#(
    parameter int ACC_BW = MATRIX_BW,
    parameter int CNT_BW = 20
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_frame_start,
    input  logic                        i_frame_end,
    input  logic                        i_valid,
    input  logic signed [ID_COE_BW-1:0] i_Ax_0,
    input  logic signed [ID_COE_BW-1:0] i_Ax_1,
    input  logic signed [ID_COE_BW-1:0] i_Ax_2,
    input  logic signed [ID_COE_BW-1:0] i_Ax_3,
    input  logic signed [ID_COE_BW-1:0] i_Ax_4,
    input  logic signed [ID_COE_BW-1:0] i_Ax_5,
    input  logic signed [ID_COE_BW-1:0] i_Ay_0,
    input  logic signed [ID_COE_BW-1:0] i_Ay_1,
    input  logic signed [ID_COE_BW-1:0] i_Ay_2,
    input  logic signed [ID_COE_BW-1:0] i_Ay_3,
    input  logic signed [ID_COE_BW-1:0] i_Ay_4,
    input  logic signed [ID_COE_BW-1:0] i_Ay_5,
    input  logic signed [ID_COE_BW-1:0] i_diffs_x,
    input  logic signed [ID_COE_BW-1:0] i_diffs_y,
    output logic                        o_done,
    output logic signed [ACC_BW-1:0]    o_H [N_H],
    output logic signed [ACC_BW-1:0]    o_b [N_B],
    output logic [CNT_BW-1:0]           o_num,
    output logic                        o_overflow
);
    localparam int PROD_BW = 2 * ID_COE_BW;

    acc_state_e state_q, state_d;
    logic [1:0] drain_cnt;
    logic       pending_q;
    logic       accept, clr, latch;
    logic [2:1] vld_pipe;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            drain_cnt <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_cnt <= (state_q == ST_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            pending_q <= (state_q == ST_DRAIN && i_frame_start) ||
                         (pending_q && state_q != ST_DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_frame_start) state_d = i_frame_end ? ST_DRAIN : ST_ACCUM;
            ST_ACCUM: if (i_frame_start) state_d = i_frame_end ? ST_DRAIN : ST_ACCUM;
                      else if (i_frame_end) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == 2'd2) state_d = ST_DONE;
            ST_DONE:  state_d = (pending_q || i_frame_start) ? ST_ACCUM : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A start seen in DRAIN/DONE only arms pending; its sample never enters the pipe.
    always_comb begin
        accept = 1'b0;
        clr    = 1'b0;
        latch  = 1'b0;
        o_done = 1'b0;
        case (state_q)
            ST_IDLE:  begin accept = i_valid && i_frame_start; clr = i_frame_start; end
            ST_ACCUM: begin accept = i_valid;                  clr = i_frame_start; end
            ST_DRAIN: latch = (drain_cnt == 2'd2);
            ST_DONE:  begin o_done = 1'b1; clr = pending_q || i_frame_start; end
            default:  ;
        endcase
    end

    // A restart kills the sample sitting in S1 so the old frame cannot leak in.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= accept;
            vld_pipe[2] <= vld_pipe[1] && !clr;
        end
    end

    logic signed [ID_COE_BW-1:0] s1_ax [6];
    logic signed [ID_COE_BW-1:0] s1_ay [6];
    logic signed [ID_COE_BW-1:0] s1_dx, s1_dy;

    always_ff @(posedge i_clk) begin
        s1_ax[0] <= i_Ax_0;  s1_ax[1] <= i_Ax_1;  s1_ax[2] <= i_Ax_2;
        s1_ax[3] <= i_Ax_3;  s1_ax[4] <= i_Ax_4;  s1_ax[5] <= i_Ax_5;
        s1_ay[0] <= i_Ay_0;  s1_ay[1] <= i_Ay_1;  s1_ay[2] <= i_Ay_2;
        s1_ay[3] <= i_Ay_3;  s1_ay[4] <= i_Ay_4;  s1_ay[5] <= i_Ay_5;
        s1_dx    <= i_diffs_x;
        s1_dy    <= i_diffs_y;
    end

    logic signed [ACC_BW-1:0] acc [N_CELL];
    logic [N_CELL-1:0]        cell_ovf;

    for (genvar n = 0; n < N_CELL; n++) begin : g_cell
        logic signed [ID_COE_BW-1:0] lx, rx, ly, ry;
        logic signed [PROD_BW-1:0]   px, py;
        logic signed [ACC_BW-1:0]    px_q, py_q;

        if (n < N_H) begin : g_h
            assign lx = s1_ax[H_ROW[n]];
            assign rx = s1_ax[H_COL[n]];
            assign ly = s1_ay[H_ROW[n]];
            assign ry = s1_ay[H_COL[n]];
        end else begin : g_b
            assign lx = s1_ax[n-N_H];
            assign rx = s1_dx;
            assign ly = s1_ay[n-N_H];
            assign ry = s1_dy;
        end

        assign px = PROD_BW'(lx) * PROD_BW'(rx);
        assign py = PROD_BW'(ly) * PROD_BW'(ry);

        always_ff @(posedge i_clk) begin
            px_q <= ACC_BW'(px >>> MUL);
            py_q <= ACC_BW'(py >>> MUL);
        end

        indirect_normal_acc_mac_cell #(.ACC_BW(ACC_BW)) u_cell (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .clr   (clr),
            .en    (vld_pipe[2]),
            .term  ({px_q[ACC_BW-1], px_q} + {py_q[ACC_BW-1], py_q}),
            .acc   (acc[n]),
            .ovf   (cell_ovf[n])
        );
    end

    logic [CNT_BW-1:0] cnt_q;
    logic              sticky_q;
    logic              cnt_sat;

    assign cnt_sat = vld_pipe[2] && (cnt_q == '1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else if (clr) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            if (vld_pipe[2] && !cnt_sat)
                cnt_q <= cnt_q + CNT_BW'(1);
            sticky_q <= sticky_q || (|cell_ovf) || cnt_sat;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int n = 0; n < N_H; n++) o_H[n] <= '0;
            for (int k = 0; k < N_B; k++) o_b[k] <= '0;
            o_num      <= '0;
            o_overflow <= 1'b0;
        end else if (latch) begin
            for (int n = 0; n < N_H; n++) o_H[n] <= acc[n];
            for (int k = 0; k < N_B; k++) o_b[k] <= acc[N_H+k];
            o_num      <= cnt_q;
            o_overflow <= sticky_q;
        end
    end
endmodule
